// File: rtl/fix_checksum_verify_if.sv
// Byte-stream, checksum and result bundle for the FIX trailer checksum verifier.
// FIX_CHK_STATS_EN adds the good/bad message counters to the bundle.
interface fix_checksum_verify_if
`ifdef FIX_CHK_STATS_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       msg_start_i;
  logic [8:0] chk_i;
  logic       chk_valid_i;
  logic       busy_o;
  logic       result_valid_o;
  logic       checksum_ok_o;
  logic [2:0] error_code_o;
  logic [7:0] rx_checksum_o;
`ifdef FIX_CHK_STATS_EN
  logic [CNT_W-1:0] good_cnt_o;
  logic [CNT_W-1:0] bad_cnt_o;

  modport master (
    output data_i, data_valid_i, msg_start_i,
    output chk_i, chk_valid_i,
    input  busy_o, result_valid_o, checksum_ok_o,
    input  error_code_o, rx_checksum_o,
    input  good_cnt_o, bad_cnt_o
  );
  modport slave (
    input  data_i, data_valid_i, msg_start_i,
    input  chk_i, chk_valid_i,
    output busy_o, result_valid_o, checksum_ok_o,
    output error_code_o, rx_checksum_o,
    output good_cnt_o, bad_cnt_o
  );
`else
  modport master (
    output data_i, data_valid_i, msg_start_i,
    output chk_i, chk_valid_i,
    input  busy_o, result_valid_o, checksum_ok_o,
    input  error_code_o, rx_checksum_o
  );
  modport slave (
    input  data_i, data_valid_i, msg_start_i,
    input  chk_i, chk_valid_i,
    output busy_o, result_valid_o, checksum_ok_o,
    output error_code_o, rx_checksum_o
  );
`endif
endinterface

// File: rtl/fix_checksum_verify.sv
// Parses the FIX "10=NNN<SOH>" trailer and checks it against the computed checksum.
// Define FIX_CHK_STATS_EN to add saturating good/bad message counters.
module fix_checksum_verify #(
  parameter int TIMEOUT_CYCLES = 64
`ifdef FIX_CHK_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clk,
  input logic rst,
  fix_checksum_verify_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_MISM    = 3'd1;
  localparam logic [2:0] C_DIGIT   = 3'd2;
  localparam logic [2:0] C_RANGE   = 3'd3;
  localparam logic [2:0] C_SOH     = 3'd4;
  localparam logic [2:0] C_TIMEOUT = 3'd5;
  localparam logic [2:0] C_RESTART = 3'd6;

  typedef enum logic [2:0] {
    IDLE, SCAN, DIGITS, TERM, WAIT_CHK, REPORT
  } state_e;

  state_e state_q, state_d;
  logic [23:0]   sr_q, sr_d;
  logic [9:0]    acc_q, acc_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic          pend_q, pend_d;
  logic [8:0]    chk_q, chk_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rescan_q, rescan_d;
  logic          ok_q, ok_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    rx_q, rx_d;

  logic          byte_v;
  logic          is_digit;
  logic          tag_hit;
  logic          restart;
  logic          chk_have;
  logic [8:0]    chk_cur;
  logic          chk_match;
  logic [23:0]   sr_first;
  logic          go_rpt;
  logic [2:0]    rpt_code;

  assign byte_v   = bus.data_valid_i;
  assign is_digit = (bus.data_i >= 8'h30) && (bus.data_i <= 8'h39);
  assign tag_hit  = {sr_q, bus.data_i} == 32'h0131303D;
  assign restart  = bus.msg_start_i && (state_q != IDLE) && (state_q != REPORT);
  assign sr_first = byte_v ? {16'h0, bus.data_i} : 24'h0;

  // A checksum pulse in the deciding cycle counts as already pending.
  assign chk_have  = pend_q | bus.chk_valid_i;
  assign chk_cur   = bus.chk_valid_i ? bus.chk_i : chk_q;
  assign chk_match = !chk_cur[8] && (chk_cur[7:0] == acc_q[7:0]);

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    dcnt_d   = dcnt_q;
    pend_d   = pend_q;
    chk_d    = chk_q;
    tmr_d    = tmr_q;
    rescan_d = rescan_q;
    ok_d     = ok_q;
    code_d   = code_q;
    rx_d     = rx_q;
    go_rpt   = 1'b0;
    rpt_code = C_NONE;

    if (state_q != IDLE && bus.chk_valid_i) begin
      pend_d = 1'b1;
      chk_d  = bus.chk_i;
    end

    case (state_q)
      IDLE: begin
        if (bus.msg_start_i) begin
          state_d = SCAN;
          sr_d    = sr_first;
          acc_d   = 10'd0;
        end
      end
      SCAN: begin
        if (byte_v) begin
          sr_d = {sr_q[15:0], bus.data_i};
          if (tag_hit) begin
            state_d = DIGITS;
            acc_d   = 10'd0;
            dcnt_d  = 2'd0;
          end
        end
      end
      DIGITS: begin
        if (byte_v) begin
          if (!is_digit) begin
            go_rpt   = 1'b1;
            rpt_code = C_DIGIT;
          end else begin
            acc_d  = (acc_q << 3) + (acc_q << 1)
                   + {6'd0, bus.data_i[3:0]};
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd2) state_d = TERM;
          end
        end
      end
      TERM: begin
        if (byte_v) begin
          if (bus.data_i != 8'h01) begin
            go_rpt   = 1'b1;
            rpt_code = C_SOH;
          end else if (acc_q > 10'd255) begin
            go_rpt   = 1'b1;
            rpt_code = C_RANGE;
          end else if (chk_have) begin
            go_rpt   = 1'b1;
            rpt_code = chk_match ? C_NONE : C_MISM;
          end else begin
            state_d = WAIT_CHK;
            tmr_d   = '0;
          end
        end
      end
      WAIT_CHK: begin
        if (chk_have) begin
          go_rpt   = 1'b1;
          rpt_code = chk_match ? C_NONE : C_MISM;
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          go_rpt   = 1'b1;
          rpt_code = C_TIMEOUT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      REPORT: begin
        pend_d   = 1'b0;
        rescan_d = 1'b0;
        if (rescan_q || bus.msg_start_i) begin
          state_d = SCAN;
          acc_d   = 10'd0;
          if (bus.msg_start_i) sr_d = sr_first;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The new message's first byte is captured now; SCAN resumes after the report.
    if (restart) begin
      go_rpt   = 1'b1;
      rpt_code = C_RESTART;
      rescan_d = 1'b1;
      sr_d     = sr_first;
    end

    if (go_rpt) begin
      state_d = REPORT;
      code_d  = rpt_code;
      ok_d    = (rpt_code == C_NONE);
      rx_d    = acc_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      dcnt_q   <= '0;
      pend_q   <= 1'b0;
      chk_q    <= '0;
      tmr_q    <= '0;
      rescan_q <= 1'b0;
      ok_q     <= 1'b0;
      code_q   <= '0;
      rx_q     <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      dcnt_q   <= dcnt_d;
      pend_q   <= pend_d;
      chk_q    <= chk_d;
      tmr_q    <= tmr_d;
      rescan_q <= rescan_d;
      ok_q     <= ok_d;
      code_q   <= code_d;
      rx_q     <= rx_d;
    end
  end

  assign bus.busy_o         = (state_q != IDLE);
  assign bus.result_valid_o = (state_q == REPORT);
  assign bus.checksum_ok_o  = ok_q;
  assign bus.error_code_o   = code_q;
  assign bus.rx_checksum_o  = rx_q;

`ifdef FIX_CHK_STATS_EN
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (state_q == REPORT) begin
      if (code_q == C_NONE) begin
        if (~&good_q) good_d = good_q + CNT_W'(1);
      end else begin
        if (~&bad_q) bad_d = bad_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign bus.good_cnt_o = good_q;
  assign bus.bad_cnt_o  = bad_q;
`endif

endmodule

// File: doc/fix_checksum_verify.md
Name: fix_checksum_verify

Overview:
- Downstream of the checksum computation stage in the FIX receive path.
- Parses the FIX trailer field "10=NNN<SOH>" from the byte stream and converts the three ASCII digits to binary.
- Compares that value with the computed checksum and emits a one-cycle pass/fail result with an error code for the message-handling logic.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait for chk_valid_i after the trailer SOH before flagging a timeout.
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_i  input  8  received message byte (ASCII).
- data_valid_i  input  1  data_i is valid this cycle.
- msg_start_i  input  1  one-cycle pulse coincident with the first byte of a message.
- chk_i  input  9  computed checksum from the checksum stage.
- chk_valid_i  input  1  one-cycle pulse; chk_i is valid.
- busy_o  output  1  a message is being tracked (state != IDLE).
- result_valid_o  output  1  one-cycle pulse; checksum_ok_o, error_code_o and rx_checksum_o are valid.
- checksum_ok_o  output  1  1 = trailer value equals computed checksum.
- error_code_o  output  3  0 none, 1 mismatch, 2 non-digit, 3 range, 4 missing SOH, 5 timeout, 6 restart.
- rx_checksum_o  output  8  binary value parsed from the trailer (low 8 bits).
- good_cnt_o  output  CNT_W  only with FIX_CHK_STATS_EN.
- bad_cnt_o  output  CNT_W  only with FIX_CHK_STATS_EN.

Behaviour:
- Reset: state IDLE; all outputs 0; internal latches and accumulators cleared.
- Byte rule: a byte is consumed only when data_valid_i=1. Cycles with data_valid_i=0 hold state and are not counted.
- IDLE -> SCAN when msg_start_i=1. The byte presented with the start pulse is consumed by SCAN.
- SCAN: 4-byte shift register matches 0x01 0x31 0x30 0x3D (SOH '1' '0' '='). On match go to DIGITS with accumulator=0 and digit count=0. The tag is only valid after an SOH; "10=" at message offset 0 does not match.
- DIGITS:
  - Each byte 0x30..0x39 updates acc = acc*10 + (byte-0x30). Accumulator width is 10 bits and cannot overflow for 3 digits.
  - Any other byte goes to REPORT with code 2.
  - After the 3rd digit go to TERM.
- TERM:
  - Byte 0x01 with acc>255: REPORT, code 3.
  - Byte 0x01 with acc<=255: WAIT_CHK.
  - Any other byte: REPORT, code 4.
- chk latch: chk_valid_i is captured into a pending flag and register in any non-IDLE state. The checksum may arrive before, during or after the trailer. A later pulse overwrites the earlier one.
- WAIT_CHK:
  - If pending is set (including a pulse in the same cycle), go to REPORT with ok = (chk_i[8]==0 && chk_i[7:0]==acc[7:0]); code 0 if ok, else 1.
  - A cycle counter starts at 0 on entry. When it reaches TIMEOUT_CYCLES with no checksum, go to REPORT with code 5.
- REPORT: result_valid_o=1 for exactly one cycle, rx_checksum_o=acc[7:0], then IDLE with pending cleared. checksum_ok_o is 1 only when code is 0.
- Latency: result_valid_o asserts 1 cycle after the trailer SOH if the checksum was already pending; otherwise 1 cycle after chk_valid_i.
- Restart: msg_start_i in any state other than IDLE or REPORT forces REPORT with code 6 (ok=0). The next cycle re-enters SCAN, consuming that message's first byte.
- msg_start_i during REPORT: report completes normally, then go to SCAN instead of IDLE.
- Bytes arriving in WAIT_CHK or REPORT are ignored.
- Outputs other than result_valid_o hold their last values until the next report.
- rst mid-message: abandons the message immediately with no report.

Optional Feature:
- FIX_CHK_STATS_EN defined:
  - good_cnt_o and bad_cnt_o exist. They increment on each report with code 0 / code !=0, saturate at all-ones, and clear on rst.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Stream "8=FIX.4.2<SOH>...<SOH>10=062<SOH>", then chk_i=62 pulse 3 cycles later -> one result_valid_o pulse, ok=1, code 0, rx_checksum_o=0x3E, pulse 1 cycle after chk_valid_i.
- chk_i=63 pulsed mid-message, trailer "10=062<SOH>" -> report 1 cycle after trailer SOH, ok=0, code 1, rx=62.
- Trailers "10=2A5", "10=300<SOH>", "10=0620" -> code 2, code 3, code 4 respectively, ok=0.
- Valid trailer, chk_valid_i never asserted, TIMEOUT_CYCLES=64 -> code 5 exactly 64 cycles after entering WAIT_CHK.
- msg_start_i during DIGITS, then a full good message -> code 6 report, then a code 0 report for the second message. data_valid_i gaps of 1-5 cycles inserted randomly must not change results.
- With FIX_CHK_STATS_EN: 3 good + 2 bad messages -> good_cnt_o=3, bad_cnt_o=2. rst mid-trailer -> no report, counters 0.
